pc_control: RTL and testbench
=============================

PC_CONTROL -- requirements
Module: pc_control

Interface
REQ-001 SHALL have port Clock, input, 1, single clock; all state updates on the rising edge.
REQ-002 SHALL have port Reset, input, 1, synchronous, active-high reset.
REQ-003 SHALL have port CounterValue, input, 16, current program counter value.
REQ-004 SHALL have port JumpReq, input, 1, absolute redirect request to JumpTarget.
REQ-005 SHALL have port JumpTarget, input, 16, absolute target address.
REQ-006 SHALL have port BranchReq, input, 1, conditional relative branch request.
REQ-007 SHALL have port BranchTaken, input, 1, branch condition, valid only with BranchReq.
REQ-008 SHALL have port BranchOffset, input, signed 9, relative displacement.
REQ-009 SHALL have port CallReq, input, 1, subroutine call to JumpTarget.
REQ-010 SHALL have port ReturnReq, input, 1, return to the top return-stack address.
REQ-011 SHALL have port LoadValue, output, 16, drives the counter load value.
REQ-012 SHALL have port LoadEnable, output, 1, one-cycle counter load strobe.
REQ-013 SHALL have port Offset, output, signed 9, drives the counter offset.
REQ-014 SHALL have port OffsetEnable, output, 1, one-cycle counter offset strobe.
REQ-015 SHALL have port Busy, output, 1, high while a redirect is in progress; requests are ignored.
REQ-016 SHALL have port Flush, output, 1, tells the fetch stage to discard the instruction in flight.
REQ-017 SHALL have port StackError, output, 1, sticky flag for return-stack overflow or underflow.

Function
REQ-018 SHALL implement FSM states RUN, REDIRECT and FLUSH: RUN to REDIRECT on an accepted request, REDIRECT to FLUSH unconditionally, FLUSH to RUN unconditionally.
REQ-019 SHALL accept requests only in RUN; Busy SHALL be 1 in REDIRECT and FLUSH and 0 in RUN.
REQ-020 SHALL resolve simultaneous requests with fixed priority ReturnReq > CallReq > JumpReq > BranchReq; lower-priority requests in the same cycle are dropped.
REQ-021 SHALL treat BranchReq with BranchTaken=0 as no request: no state change and no strobe.
REQ-022 SHALL register outputs so that a request accepted in cycle N produces a strobe in cycle N+1 only, lasting exactly one cycle.
REQ-023 Jump and call SHALL drive LoadValue=JumpTarget with LoadEnable=1.
REQ-024 A taken branch SHALL drive Offset=BranchOffset with OffsetEnable=1; the counter computes CounterValue+Offset with 16-bit wrap.
REQ-025 SHALL never assert LoadEnable and OffsetEnable in the same cycle.
REQ-026 SHALL hold LoadValue and Offset at their last driven values while the strobes are low.
REQ-027 SHALL assert Flush in the REDIRECT and FLUSH cycles (2 cycles) and hold it low otherwise.
REQ-028 A call SHALL push CounterValue+1 (mod 2^16), sampled in the accept cycle, onto a 4-entry LIFO return stack.
REQ-029 A return SHALL pop the top entry and drive it as LoadValue with LoadEnable=1.
REQ-030 A call with the stack full SHALL still redirect, SHALL discard the push and SHALL set StackError.
REQ-031 A return with the stack empty SHALL be ignored (FSM stays in RUN) and SHALL set StackError.
REQ-032 StackError SHALL stay set until Reset.

Reset
REQ-033 SHALL place the FSM in RUN while Reset=1, taking priority over any request in the same cycle.
REQ-034 SHALL drive LoadEnable=0, OffsetEnable=0, Busy=0, Flush=0, StackError=0, LoadValue=0 and Offset=0 on reset.
REQ-035 SHALL empty the return stack on reset; a Reset asserted during REDIRECT or FLUSH SHALL suppress any pending strobe.

Configuration
REQ-036 SHALL compile the return stack only when macro PC_CONTROL_RAS_EN is defined.
REQ-037 Without PC_CONTROL_RAS_EN, CallReq SHALL behave exactly as JumpReq, ReturnReq SHALL be ignored and StackError SHALL be tied to 0.

Verification
REQ-038 Reset, then JumpReq=1 with JumpTarget=1000 for one cycle -> one cycle later LoadEnable=1 and LoadValue=1000; Busy and Flush high for 2 cycles; CounterValue=1000 after the strobe.
REQ-039 CounterValue=1010, BranchReq=1, BranchTaken=1, BranchOffset=-200 -> OffsetEnable=1 and Offset=-200 for one cycle; counter becomes 810. The same stimulus with BranchTaken=0 -> no strobe and Busy stays 0.
REQ-040 CallReq with JumpTarget=0x0200 at CounterValue=0x0050, then a later ReturnReq -> LoadValue=0x0200, then LoadValue=0x0051.
REQ-041 Same cycle with ReturnReq, JumpReq and BranchReq taken -> only the return load occurs. A JumpReq issued while Busy=1 -> ignored.
REQ-042 Five successive calls -> StackError=1 after the fifth, and five returns yield 4 valid loads. ReturnReq after reset -> StackError=1 with no strobe.
REQ-043 Reset asserted in the REDIRECT cycle -> no strobe; FSM in RUN and all outputs 0 on the next cycle.

Source files
------------

// File: rtl/pc_control.sv
// pc_control: program-counter redirect controller (jump/branch/call/return) with 3-state flush FSM.
// Optional 4-entry return stack compiled only with `define PC_CONTROL_RAS_EN.
module pc_control (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [15:0]       CounterValue,
  input  logic              JumpReq,
  input  logic [15:0]       JumpTarget,
  input  logic              BranchReq,
  input  logic              BranchTaken,
  input  logic signed [8:0] BranchOffset,
  input  logic              CallReq,
  input  logic              ReturnReq,
  output logic [15:0]       LoadValue,
  output logic              LoadEnable,
  output logic signed [8:0] Offset,
  output logic              OffsetEnable,
  output logic              Busy,
  output logic              Flush,
  output logic              StackError
);
  typedef enum logic [1:0] {RUN, REDIRECT, FLUSH} state_t;
  state_t r_state, w_next;
  logic r_load_en, r_off_en;
  logic [15:0] w_top, w_load_val;
  logic w_ret, w_empty, w_full, w_run, w_pop, w_call, w_jump, w_br, w_load, w_accept;
`ifdef PC_CONTROL_RAS_EN
  logic [15:0] r_stack [4];
  logic [2:0] r_sp;
  logic r_err;
  logic w_push, w_err_set;
  assign w_ret = ReturnReq;
  assign w_empty = r_sp == 3'd0;
  assign w_full = r_sp == 3'd4;
  assign w_top = r_stack[r_sp[1:0] - 2'd1];
  assign w_push = w_call & ~w_full;
  // an empty-stack return is consumed (blocks lower requests) but does nothing else
  assign w_err_set = (w_run & w_ret & w_empty) | (w_call & w_full);
  assign StackError = r_err;
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_sp <= 3'd0;
      r_err <= 1'b0;
    end else begin
      if (w_push) begin
        r_stack[r_sp[1:0]] <= CounterValue + 16'd1;
        r_sp <= r_sp + 3'd1;
      end else if (w_pop) r_sp <= r_sp - 3'd1;
      if (w_err_set) r_err <= 1'b1;
    end
  end
`else
  logic w_unused;
  assign w_unused = ^{ReturnReq, CounterValue};
  assign w_ret = 1'b0;
  assign w_empty = 1'b1;
  assign w_full = 1'b0;
  assign w_top = 16'd0;
  assign StackError = 1'b0;
`endif
  assign w_run = r_state == RUN;
  assign w_pop = w_run & w_ret & ~w_empty;
  assign w_call = w_run & ~w_ret & CallReq;
  assign w_jump = w_run & ~w_ret & ~CallReq & JumpReq;
  assign w_br = w_run & ~w_ret & ~CallReq & ~JumpReq & BranchReq & BranchTaken;
  assign w_load = w_pop | w_call | w_jump;
  assign w_accept = w_load | w_br;
  assign w_load_val = w_pop ? w_top : JumpTarget;
  always_comb begin
    w_next = RUN;
    w_next = w_run ? (w_accept ? REDIRECT : RUN) : (r_state == REDIRECT ? FLUSH : RUN);
  end
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state <= RUN;
      r_load_en <= 1'b0;
      r_off_en <= 1'b0;
      LoadValue <= 16'd0;
      Offset <= 9'sd0;
    end else begin
      r_state <= w_next;
      r_load_en <= w_load;
      r_off_en <= w_br;
      if (w_load) LoadValue <= w_load_val;
      if (w_br) Offset <= BranchOffset;
    end
  end
  // reset landing on the strobe cycle must keep the counter from loading
  assign LoadEnable = r_load_en & ~Reset;
  assign OffsetEnable = r_off_en & ~Reset;
  assign Busy = r_state != RUN;
  assign Flush = r_state != RUN;
endmodule

// File: tb/tb_pc_control.sv
// tb_pc_control: directed table-driven bench for pc_control, with a simple counter model driving CounterValue.
module tb_pc_control;
  logic Clock = 1'b0, Reset = 1'b1;
  logic [15:0] CounterValue = 16'd0, JumpTarget = 16'd0;
  logic JumpReq = 1'b0, BranchReq = 1'b0, BranchTaken = 1'b0, CallReq = 1'b0, ReturnReq = 1'b0;
  logic signed [8:0] BranchOffset = 9'sd0;
  logic [15:0] LoadValue;
  logic LoadEnable, OffsetEnable, Busy, Flush, StackError;
  logic signed [8:0] Offset;
  int n_cmp = 0, n_bad = 0;

  pc_control dut (
    .Clock(Clock), .Reset(Reset), .CounterValue(CounterValue), .JumpReq(JumpReq),
    .JumpTarget(JumpTarget), .BranchReq(BranchReq), .BranchTaken(BranchTaken),
    .BranchOffset(BranchOffset), .CallReq(CallReq), .ReturnReq(ReturnReq),
    .LoadValue(LoadValue), .LoadEnable(LoadEnable), .Offset(Offset),
    .OffsetEnable(OffsetEnable), .Busy(Busy), .Flush(Flush), .StackError(StackError)
  );

  always #5 Clock = ~Clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic jr; logic [15:0] jt; logic br; logic bt; logic signed [8:0] bo; logic [15:0] cv;
    logic le; logic oe; logic [15:0] lv; logic signed [8:0] off; logic busy; logic [15:0] cv_out;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // counter model: consumes the strobes the way the program counter would
  task automatic tick();
    @(posedge Clock);
    #1;
    if (LoadEnable) CounterValue = LoadValue;
    else if (OffsetEnable) CounterValue = CounterValue + {{7{Offset[8]}}, Offset};
  endtask

  task automatic clr();
    JumpReq = 0; BranchReq = 0; BranchTaken = 0; CallReq = 0; ReturnReq = 0;
  endtask

  task automatic settle();
    tick(); tick(); tick();
  endtask

  vec_t v [7];
  logic [15:0] exp_ret [4];
  int loads;

  initial begin
    v[0] = '{1, 16'd1000,   0, 0, 9'sd0,    16'd0,      1, 0, 16'd1000,   9'sd0,    1, 16'd1000};
    v[1] = '{0, 16'd0,      1, 1, -9'sd200, 16'd1010,   0, 1, 16'd1000,   -9'sd200, 1, 16'd810};
    v[2] = '{0, 16'd0,      1, 0, -9'sd200, 16'd1010,   0, 0, 16'd1000,   -9'sd200, 0, 16'd1010};
    v[3] = '{1, 16'h1234,   1, 1, 9'sd5,    16'd7,      1, 0, 16'h1234,   -9'sd200, 1, 16'h1234};
    v[4] = '{0, 16'd0,      1, 1, 9'sd255,  16'hFFF0,   0, 1, 16'h1234,   9'sd255,  1, 16'h00EF};
    v[5] = '{0, 16'd0,      1, 1, -9'sd256, 16'h0010,   0, 1, 16'h1234,   -9'sd256, 1, 16'hFF10};
    v[6] = '{1, 16'hFFFF,   1, 0, 9'sd3,    16'd5,      1, 0, 16'hFFFF,   -9'sd256, 1, 16'hFFFF};

    tick(); tick();
    chk("rst_le", LoadEnable, 0); chk("rst_oe", OffsetEnable, 0); chk("rst_busy", Busy, 0);
    chk("rst_flush", Flush, 0); chk("rst_err", StackError, 0); chk("rst_lv", LoadValue, 0);
    chk("rst_off", Offset, 0);
    Reset = 0;
    tick();

    for (int i = 0; i < 7; i++) begin
      CounterValue = v[i].cv; JumpReq = v[i].jr; JumpTarget = v[i].jt;
      BranchReq = v[i].br; BranchTaken = v[i].bt; BranchOffset = v[i].bo;
      tick();
      clr();
      chk($sformatf("v%0d_le", i), LoadEnable, v[i].le);
      chk($sformatf("v%0d_oe", i), OffsetEnable, v[i].oe);
      chk($sformatf("v%0d_lv", i), LoadValue, v[i].lv);
      chk($sformatf("v%0d_off", i), Offset, v[i].off);
      chk($sformatf("v%0d_busy", i), Busy, v[i].busy);
      chk($sformatf("v%0d_flush", i), Flush, v[i].busy);
      tick();
      chk($sformatf("v%0d_le2", i), LoadEnable | OffsetEnable, 0);
      chk($sformatf("v%0d_busy2", i), Busy, v[i].busy);
      tick();
      chk($sformatf("v%0d_busy3", i), Busy | Flush, 0);
      chk($sformatf("v%0d_cv", i), CounterValue, v[i].cv_out);
    end

    // requests during Busy are ignored
    JumpReq = 1; JumpTarget = 16'd100;
    tick();
    JumpTarget = 16'd200;
    chk("busy_lv", LoadValue, 16'd100);
    tick();
    chk("busy_ign_le", LoadEnable, 0); chk("busy_flush2", Flush, 1);
    clr();
    tick();
    chk("busy_ign_le2", LoadEnable, 0); chk("busy_ign_busy", Busy, 0);
    chk("busy_ign_lv", LoadValue, 16'd100);

    // reset during REDIRECT suppresses the strobe
    JumpReq = 1; JumpTarget = 16'd300;
    tick();
    clr();
    Reset = 1;
    #1;
    chk("rstred_le", LoadEnable, 0);
    tick();
    Reset = 0;
    chk("rstred_busy", Busy, 0); chk("rstred_flush", Flush, 0); chk("rstred_lv", LoadValue, 0);
    chk("rstred_le2", LoadEnable, 0); chk("rstred_off", Offset, 0);
    tick();
    chk("rstred_le3", LoadEnable, 0);

    // reset wins over a same-cycle request
    Reset = 1; JumpReq = 1; JumpTarget = 16'd400;
    tick();
    Reset = 0; clr();
    tick();
    chk("rstpri_le", LoadEnable, 0); chk("rstpri_busy", Busy, 0);

`ifdef PC_CONTROL_RAS_EN
    CounterValue = 16'h0050; CallReq = 1; JumpTarget = 16'h0200;
    tick(); clr();
    chk("call_le", LoadEnable, 1); chk("call_lv", LoadValue, 16'h0200);
    settle();
    ReturnReq = 1;
    tick(); clr();
    chk("ret_le", LoadEnable, 1); chk("ret_lv", LoadValue, 16'h0051);
    settle();
    CounterValue = 16'h0010; CallReq = 1; JumpTarget = 16'h0300;
    tick(); clr(); settle();
    ReturnReq = 1; JumpReq = 1; JumpTarget = 16'h0777; BranchReq = 1; BranchTaken = 1; BranchOffset = 9'sd9;
    tick(); clr();
    chk("pri_le", LoadEnable, 1); chk("pri_oe", OffsetEnable, 0); chk("pri_lv", LoadValue, 16'h0011);
    settle();
    chk("pri_single", LoadEnable | OffsetEnable, 0);
    ReturnReq = 1;
    tick(); clr();
    chk("under_le", LoadEnable, 0); chk("under_busy", Busy, 0); chk("under_err", StackError, 1);
    Reset = 1; tick(); Reset = 0; tick();
    chk("err_clr", StackError, 0);
    for (int i = 1; i <= 5; i++) begin
      CounterValue = 16'(i * 10); CallReq = 1; JumpTarget = 16'(16'h0100 + i);
      tick(); clr();
      chk($sformatf("call%0d_lv", i), LoadValue, 16'h0100 + i);
      chk($sformatf("call%0d_err", i), StackError, i == 5);
      settle();
    end
    exp_ret = '{16'd41, 16'd31, 16'd21, 16'd11};
    loads = 0;
    for (int i = 0; i < 5; i++) begin
      ReturnReq = 1;
      tick(); clr();
      if (i < 4) chk($sformatf("ret%0d_lv", i), LoadValue, exp_ret[i]);
      if (LoadEnable) loads++;
      settle();
    end
    chk("ret_loads", loads, 4);
    chk("ret_err_sticky", StackError, 1);
`else
    CounterValue = 16'h0050; CallReq = 1; JumpTarget = 16'h0200;
    tick(); clr();
    chk("call_le", LoadEnable, 1); chk("call_lv", LoadValue, 16'h0200);
    settle();
    ReturnReq = 1;
    tick(); clr();
    chk("ret_ign_le", LoadEnable, 0); chk("ret_ign_busy", Busy, 0); chk("ret_err0", StackError, 0);
    ReturnReq = 1; JumpReq = 1; JumpTarget = 16'h0777;
    tick(); clr();
    chk("ret_jump_le", LoadEnable, 1); chk("ret_jump_lv", LoadValue, 16'h0777);
    settle();
    CallReq = 1; JumpTarget = 16'h0123; BranchReq = 1; BranchTaken = 1; BranchOffset = 9'sd4;
    tick(); clr();
    chk("callbr_le", LoadEnable, 1); chk("callbr_oe", OffsetEnable, 0); chk("callbr_lv", LoadValue, 16'h0123);
    settle();
    chk("noras_err", StackError, 0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
